pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Selects the next-PC source; handles load-use stalls, taken branches/jumps resolved in MEM, MEM-stage exceptions (overflow/undefined), data-memory busy freeze and exception return.

---
 rtl/pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for a 5-stage pipeline. Drives
//             the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM
//             and MEM/WB, and selects the next-PC source. Handles load-use
//             stalls, MEM-resolved branches/jumps, MEM-stage exceptions
//             (overflow / undefined opcode), data-memory busy freeze and
//             exception return.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LU_STALL_CYCLES : bubbles per load-use hazard (1..3)
//    EXC_MASK_NEST   : 1 = ignore new exceptions while one is active,
//                      0 = accept nested exceptions (EPC/cause overwritten)
//  Optional feature macro
//    HAZ_PERF_CNT_EN : when defined, stall_cnt_o / flush_cnt_o are live
//                      performance counters; otherwise both are tied to 0.
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_ni           : clock, asynchronous active-low reset
//    id_*_i                  : source registers of the instruction in ID
//    ex_*_i                  : load / writeback info of the instruction in EX
//    mem_*_i                 : branch/jump/exception info of instruction in MEM
//    eret_i                  : exception-return pulse from ID decode
//    dmem_busy_i             : data memory not ready (freezes the pipeline)
//    *_we_o / *_flush_o      : pipeline register enables / bubble insertion
//    pc_sel_o                : 0 PC+4, 1 branch, 2 jump, 3 exc vector, 4 EPC
//    epc_o, cause_o          : captured exception PC and cause
//    exc_active_o            : exception handler running
//    stall_cnt_o/flush_cnt_o : performance counters
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int EXC_MASK_NEST   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rs_i,
    input  logic        id_uses_rt_i,
    input  logic        ex_memtoreg_i,
    input  logic        ex_regwrite_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        mem_branch_i,
    input  logic        mem_zero_i,
    input  logic        mem_jump_i,
    input  logic        mem_overflow_i,
    input  logic        mem_undefine_i,
    input  logic [31:0] mem_pc_i,
    input  logic        eret_i,
    input  logic        dmem_busy_i,
    output logic        pc_we_o,
    output logic        if_id_we_o,
    output logic        id_ex_we_o,
    output logic        ex_mem_we_o,
    output logic        mem_wb_we_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic        mem_wb_flush_o,
    output logic [2:0]  pc_sel_o,
    output logic [31:0] epc_o,
    output logic [1:0]  cause_o,
    output logic        exc_active_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_EXC    = 2'd2
    } state_e;

    localparam logic [2:0] PCSEL_SEQ    = 3'd0;
    localparam logic [2:0] PCSEL_BRANCH = 3'd1;
    localparam logic [2:0] PCSEL_JUMP   = 3'd2;
    localparam logic [2:0] PCSEL_EXC    = 3'd3;
    localparam logic [2:0] PCSEL_EPC    = 3'd4;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_UND  = 2'b10;

    // Remaining bubbles loaded when a multi-cycle load-use stall starts; the
    // hazard cycle itself is the first bubble.
    localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYCLES - 1);
    localparam bit         MASK_NEST = (EXC_MASK_NEST != 0);

    state_e      state_q, state_d;
    logic [1:0]  bub_cnt_q, bub_cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic        exc_active_q, exc_active_d;

    logic        w_exc_req;
    logic        w_taken;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_load_use;
    state_e      w_resume_state;

    assign w_exc_req  = (mem_overflow_i | mem_undefine_i) & ~(exc_active_q & MASK_NEST);
    assign w_taken    = (mem_branch_i & mem_zero_i) | mem_jump_i;
    assign w_rs_hit   = id_uses_rs_i & (id_rs_i == ex_rd_i);
    assign w_rt_hit   = id_uses_rt_i & (id_rt_i == ex_rd_i);
    // $0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = ex_memtoreg_i & ex_regwrite_i & (ex_rd_i != 5'd0) & (w_rs_hit | w_rt_hit);

    // A stall that is aborted or finishes returns to the handler state when
    // an exception is still being serviced.
    assign w_resume_state = exc_active_q ? ST_EXC : ST_RUN;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_RUN;
            bub_cnt_q    <= 2'd0;
            epc_q        <= 32'd0;
            cause_q      <= CAUSE_NONE;
            exc_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bub_cnt_q    <= bub_cnt_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            exc_active_q <= exc_active_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode, highest priority first
    // ------------------------------------------------------------------
    always_comb begin
        pc_we_o        = 1'b1;
        if_id_we_o     = 1'b1;
        id_ex_we_o     = 1'b1;
        ex_mem_we_o    = 1'b1;
        mem_wb_we_o    = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        pc_sel_o       = PCSEL_SEQ;
        state_d        = state_q;
        bub_cnt_d      = bub_cnt_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        exc_active_d   = exc_active_q;

        if (!rst_ni) begin
            // Hold every stage and fill the pipe with bubbles during reset.
            pc_we_o        = 1'b0;
            if_id_we_o     = 1'b0;
            id_ex_we_o     = 1'b0;
            ex_mem_we_o    = 1'b0;
            mem_wb_we_o    = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (dmem_busy_i) begin
            // Full freeze: MEM is held, so any pending event in MEM is
            // simply re-evaluated once the memory is ready.
            pc_we_o     = 1'b0;
            if_id_we_o  = 1'b0;
            id_ex_we_o  = 1'b0;
            ex_mem_we_o = 1'b0;
            mem_wb_we_o = 1'b0;
        end else if (w_exc_req) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            mem_wb_flush_o = 1'b1;
            pc_sel_o       = PCSEL_EXC;
            epc_d          = mem_pc_i;
            cause_d        = mem_undefine_i ? CAUSE_UND : CAUSE_OVF;
            exc_active_d   = 1'b1;
            state_d        = ST_EXC;
            bub_cnt_d      = 2'd0;
        end else if (w_taken) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            pc_sel_o       = mem_jump_i ? PCSEL_JUMP : PCSEL_BRANCH;
            state_d        = w_resume_state;
            bub_cnt_d      = 2'd0;
        end else if (eret_i && exc_active_q) begin
            if_id_flush_o = 1'b1;
            pc_sel_o      = PCSEL_EPC;
            exc_active_d  = 1'b0;
            cause_d       = CAUSE_NONE;
            state_d       = ST_RUN;
            bub_cnt_d     = 2'd0;
        end else if (w_load_use) begin
            pc_we_o       = 1'b0;
            if_id_we_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                state_d   = ST_LSTALL;
                bub_cnt_d = LU_RELOAD;
            end
        end else if (state_q == ST_LSTALL) begin
            pc_we_o       = 1'b0;
            if_id_we_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            bub_cnt_d     = bub_cnt_q - 2'd1;
            if (bub_cnt_q == 2'd1) begin
                state_d = w_resume_state;
            end
        end
    end

    assign epc_o        = epc_q;
    assign cause_o      = cause_q;
    assign exc_active_o = exc_active_q;

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Outside reset, if_id_flush_o is only raised by an exception, a taken
    // redirect or an eret, so it directly marks a control-flow flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!pc_we_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_id_flush_o) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl. A behavioural model
//             tracks "bubbles still owed", exception status and counters and
//             predicts every output each cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int LU   = 2;
    localparam int MASK = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_memtoreg, ex_regwrite;
    logic        mem_branch, mem_zero, mem_jump, mem_overflow, mem_undefine;
    logic [31:0] mem_pc;
    logic        eret, dmem_busy;

    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [2:0]  pc_sel;
    logic [31:0] epc, stall_cnt, flush_cnt;
    logic [1:0]  cause;
    logic        exc_active;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state
    int          m_left;     // stall cycles still owed after the current one
    bit          m_exc;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    logic [31:0] m_sc, m_fc;

    pipe_hazard_ctrl #(
        .LU_STALL_CYCLES (LU),
        .EXC_MASK_NEST   (MASK)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rs_i   (id_uses_rs),
        .id_uses_rt_i   (id_uses_rt),
        .ex_memtoreg_i  (ex_memtoreg),
        .ex_regwrite_i  (ex_regwrite),
        .ex_rd_i        (ex_rd),
        .mem_branch_i   (mem_branch),
        .mem_zero_i     (mem_zero),
        .mem_jump_i     (mem_jump),
        .mem_overflow_i (mem_overflow),
        .mem_undefine_i (mem_undefine),
        .mem_pc_i       (mem_pc),
        .eret_i         (eret),
        .dmem_busy_i    (dmem_busy),
        .pc_we_o        (pc_we),
        .if_id_we_o     (if_id_we),
        .id_ex_we_o     (id_ex_we),
        .ex_mem_we_o    (ex_mem_we),
        .mem_wb_we_o    (mem_wb_we),
        .if_id_flush_o  (if_id_flush),
        .id_ex_flush_o  (id_ex_flush),
        .ex_mem_flush_o (ex_mem_flush),
        .mem_wb_flush_o (mem_wb_flush),
        .pc_sel_o       (pc_sel),
        .epc_o          (epc),
        .cause_o        (cause),
        .exc_active_o   (exc_active),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_memtoreg = 1'b0; ex_regwrite = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0;
        mem_overflow = 1'b0; mem_undefine = 1'b0; mem_pc = 32'd0;
        eret = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
        id_rs = rd; id_uses_rs = 1'b1;
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // At the falling edge: compare all outputs with the model's prediction
    // for the current inputs, then advance the model by one cycle.
    task automatic eval();
        logic [4:0] e_we;
        logic [3:0] e_fl;
        logic [2:0] e_sel;
        bit exc_ev, taken, haz, ctl_flush;
        @(negedge clk);
        if (!rst_n) begin
            m_left = 0; m_exc = 0; m_epc = 0; m_cause = 0; m_sc = 0; m_fc = 0;
        end
        check("epc", epc, m_epc);
        check("cause", {30'd0, cause}, {30'd0, m_cause});
        check("exc_active", {31'd0, exc_active}, {31'd0, m_exc});
`ifdef HAZ_PERF_CNT_EN
        check("stall_cnt", stall_cnt, m_sc);
        check("flush_cnt", flush_cnt, m_fc);
`else
        check("stall_cnt", stall_cnt, 32'd0);
        check("flush_cnt", flush_cnt, 32'd0);
`endif
        e_we = 5'h1F; e_fl = 4'h0; e_sel = 3'd0; ctl_flush = 0;
        if (!rst_n) begin
            e_we = 5'h00; e_fl = 4'hF;
        end else begin
            exc_ev = (mem_overflow || mem_undefine) && !(m_exc && MASK != 0);
            taken  = (mem_branch && mem_zero) || mem_jump;
            haz    = ex_memtoreg && ex_regwrite && ex_rd != 0 &&
                     ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
            if (dmem_busy) begin
                e_we = 5'h00;
            end else if (exc_ev) begin
                e_fl = 4'hF; e_sel = 3'd3; ctl_flush = 1;
                m_epc = mem_pc; m_cause = mem_undefine ? 2'b10 : 2'b01;
                m_exc = 1; m_left = 0;
            end else if (taken) begin
                e_fl = 4'hE; e_sel = mem_jump ? 3'd2 : 3'd1; ctl_flush = 1;
                m_left = 0;
            end else if (eret && m_exc) begin
                e_fl = 4'h8; e_sel = 3'd4; ctl_flush = 1;
                m_exc = 0; m_cause = 0; m_left = 0;
            end else if (haz) begin
                e_we = 5'h07; e_fl = 4'h4;
                m_left = LU - 1;
            end else if (m_left > 0) begin
                e_we = 5'h07; e_fl = 4'h4;
                m_left = m_left - 1;
            end
            if (e_we[4] == 1'b0) m_sc = m_sc + 32'd1;
            if (ctl_flush) m_fc = m_fc + 32'd1;
        end
        check("we", {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, {27'd0, e_we});
        check("flush", {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {28'd0, e_fl});
        check("pc_sel", {29'd0, pc_sel}, {29'd0, e_sel});
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        m_left = 0; m_exc = 0; m_epc = 0; m_cause = 0; m_sc = 0; m_fc = 0;

        // Reset state
        eval();
        check("lit_rst_pc_we", {31'd0, pc_we}, 32'd0);
        check("lit_rst_mem_wb_flush", {31'd0, mem_wb_flush}, 32'd1);
        check("lit_rst_epc", epc, 32'd0);
        adv(); rst_n = 1'b1;
        eval();
        check("lit_run_pc_we", {31'd0, pc_we}, 32'd1);

        // Load-use on $5: exactly two stall cycles, then running again
        adv(); load_use(5'd5);
        eval();
        check("lit_lu_c1_pc_we", {31'd0, pc_we}, 32'd0);
        check("lit_lu_c1_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        adv(); idle();
        eval();
        check("lit_lu_c2_pc_we", {31'd0, pc_we}, 32'd0);
        check("lit_lu_c2_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        adv();
        eval();
        check("lit_lu_done_pc_we", {31'd0, pc_we}, 32'd1);

        // Same pattern on $0: no hazard
        adv(); load_use(5'd0);
        eval();
        check("lit_r0_pc_we", {31'd0, pc_we}, 32'd1);

        // Taken branch during the second stall cycle aborts the stall
        adv(); load_use(5'd7);
        eval();
        adv(); idle(); mem_branch = 1'b1; mem_zero = 1'b1;
        eval();
        check("lit_br_pc_sel", {29'd0, pc_sel}, 32'd1);
        check("lit_br_flush", {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, 32'hE);
        adv(); idle();
        eval();
        check("lit_br_after_pc_we", {31'd0, pc_we}, 32'd1);

        // Overflow exception, masked nested exception, then eret
        adv(); mem_overflow = 1'b1; mem_pc = 32'h0000_0040;
        eval();
        check("lit_exc_pc_sel", {29'd0, pc_sel}, 32'd3);
        check("lit_exc_mem_wb_flush", {31'd0, mem_wb_flush}, 32'd1);
        adv(); idle();
        eval();
        check("lit_exc_epc", epc, 32'h40);
        check("lit_exc_cause", {30'd0, cause}, 32'd1);
        check("lit_exc_active", {31'd0, exc_active}, 32'd1);
        adv(); mem_overflow = 1'b1; mem_pc = 32'h0000_0080;
        eval();
        check("lit_nest_pc_sel", {29'd0, pc_sel}, 32'd0);
        adv(); idle(); eret = 1'b1;
        eval();
        check("lit_nest_epc", epc, 32'h40);
        check("lit_eret_pc_sel", {29'd0, pc_sel}, 32'd4);
        adv(); idle();
        eval();
        check("lit_eret_exc_active", {31'd0, exc_active}, 32'd0);

        // dmem_busy for three cycles while a jump waits in MEM
        for (int i = 0; i < 3; i++) begin
            adv(); dmem_busy = 1'b1; mem_jump = 1'b1;
            eval();
            check("lit_busy_we", {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'd0);
        end
        adv(); dmem_busy = 1'b0;
        eval();
        check("lit_jmp_pc_sel", {29'd0, pc_sel}, 32'd2);
        check("lit_jmp_if_id_flush", {31'd0, if_id_flush}, 32'd1);

        // Reset asserted in the middle of a load-use stall
        adv(); idle(); load_use(5'd9);
        eval();
        adv(); idle(); rst_n = 1'b0;
        eval();
        check("lit_midrst_stall_cnt", stall_cnt, 32'd0);
        check("lit_midrst_if_id_flush", {31'd0, if_id_flush}, 32'd1);
        adv(); rst_n = 1'b1;
        eval();
        check("lit_midrst_after_pc_we", {31'd0, pc_we}, 32'd1);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            adv();
            rst_n        = ($urandom_range(0, 199) != 0);
            dmem_busy    = ($urandom_range(0, 9) == 0);
            mem_overflow = ($urandom_range(0, 24) == 0);
            mem_undefine = ($urandom_range(0, 24) == 0);
            mem_pc       = $urandom;
            mem_branch   = ($urandom_range(0, 7) == 0);
            mem_zero     = $urandom_range(0, 1) == 1;
            mem_jump     = ($urandom_range(0, 15) == 0);
            eret         = ($urandom_range(0, 7) == 0);
            ex_memtoreg  = ($urandom_range(0, 2) == 0);
            ex_regwrite  = ($urandom_range(0, 3) != 0);
            ex_rd        = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rs   = $urandom_range(0, 1) == 1;
            id_uses_rt   = $urandom_range(0, 1) == 1;
            eval();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
